// File: rtl/cache_buffer_responder.sv
// cache_buffer_responder
//   Memory-side responder for the L2 cache buffer interface. Accepts single-word
//   or block requests, fetches read words from a fixed-latency backing memory
//   into a word FIFO, and collects write words from the cache into the same FIFO
//   before draining them to memory.
//
// Ports
//   clock_i, resetn_i            clock, asynchronous active-low reset
//   req_i/req_block_i/rw_i/add_i request strobe, block/single, write/read, word address
//   write_i/data_i               cache pushes a write word
//   read_i/data_o                cache pops a read word (data_o = FIFO head)
//   mem_data_i                   backing-memory read data, MEM_LATENCY after issue
//   ready_req_o/_write_o/_read_o handshake readiness
//   mem_en_o/mem_we_o/mem_add_o/mem_data_o  SRAM-style memory port
//   error_o                      sticky protocol-violation flag
//
// Outputs are decoded only from registered state and FIFO occupancy, so a
// request accepted at edge N drives its first memory access in cycle N+1.
module cache_buffer_responder #(
  parameter int unsigned BW_WORD_ADDR = 24,
  parameter int unsigned BW_BLOCK     = 2,
  parameter int unsigned MEM_LATENCY  = 2
) (
  input  logic                    clock_i,
  input  logic                    resetn_i,
  input  logic                    req_i,
  input  logic                    req_block_i,
  input  logic                    rw_i,
  input  logic [BW_WORD_ADDR-1:0] add_i,
  input  logic                    write_i,
  input  logic                    read_i,
  input  logic [31:0]             data_i,
  input  logic [31:0]             mem_data_i,
  output logic                    ready_req_o,
  output logic                    ready_write_o,
  output logic                    ready_read_o,
  output logic [31:0]             data_o,
  output logic                    mem_en_o,
  output logic                    mem_we_o,
  output logic [BW_WORD_ADDR-1:0] mem_add_o,
  output logic [31:0]             mem_data_o,
  output logic                    error_o
);

  localparam int unsigned AW     = BW_WORD_ADDR;
  localparam int unsigned DW     = 32;
  localparam int unsigned PTR_W  = BW_BLOCK;
  localparam int unsigned CNT_W  = BW_BLOCK + 1;
  localparam int unsigned DEPTH  = 1 << BW_BLOCK;
  localparam int unsigned PIPE_W = MEM_LATENCY;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        base_q, base_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     issued_q, issued_d;   // read words sent to memory
  logic [CNT_W-1:0]     done_q, done_d;       // read words popped / write words drained
  logic [CNT_W-1:0]     recv_q, recv_d;       // write words accepted from the cache
  logic [DW-1:0]        fifo_q [DEPTH];
  logic [DW-1:0]        fifo_d [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     occ_q, occ_d;
  logic [PIPE_W-1:0]    pipe_q, pipe_d;       // one bit per outstanding memory read
  logic                 error_q, error_d;

  logic [CNT_W-1:0]     inflight;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 issue;
  logic                 capture;
  logic                 rd_pop;
  logic                 wr_push;
  logic                 mem_wr;
  logic                 push;
  logic                 pop;
  logic [DW-1:0]        push_data;

  // State register
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, FIFO and in-flight pipeline registers
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      base_q   <= '0;
      count_q  <= '0;
      issued_q <= '0;
      done_q   <= '0;
      recv_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      pipe_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      base_q   <= base_d;
      count_q  <= count_d;
      issued_q <= issued_d;
      done_q   <= done_d;
      recv_q   <= recv_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      pipe_q   <= pipe_d;
      error_q  <= error_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    issued_d  = issued_q;
    done_d    = done_q;
    recv_d    = recv_q;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    pipe_d    = pipe_q;
    error_d   = error_q;

    ready_req_o   = 1'b0;
    ready_write_o = 1'b0;
    ready_read_o  = 1'b0;
    mem_en_o      = 1'b0;
    mem_we_o      = 1'b0;
    mem_add_o     = '0;
    data_o        = fifo_q[rd_ptr_q];
    mem_data_o    = fifo_q[rd_ptr_q];
    error_o       = error_q;

    inflight  = '0;
    issue     = 1'b0;
    capture   = 1'b0;
    rd_pop    = 1'b0;
    wr_push   = 1'b0;
    mem_wr    = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = '0;

    for (int unsigned i = 0; i < PIPE_W; i++) begin
      inflight = inflight + CNT_W'(pipe_q[i]);
    end
    fifo_empty = (occ_q == '0);
    fifo_full  = (occ_q == CNT_W'(DEPTH));

    case (state_q)
      S_IDLE: begin
        ready_req_o = 1'b1;
        if (req_i) begin
          base_d   = req_block_i ? (add_i & ~AW'(DEPTH - 1)) : add_i;
          count_d  = req_block_i ? CNT_W'(DEPTH) : CNT_W'(1);
          issued_d = '0;
          done_d   = '0;
          recv_d   = '0;
          state_d  = rw_i ? S_WRITE : S_READ;
        end
      end

      S_READ: begin
        ready_read_o = !fifo_empty;
        // Throttle so every outstanding return is guaranteed a FIFO slot
        issue   = (issued_q < count_q) &&
                  (({1'b0, occ_q} + {1'b0, inflight}) < (CNT_W + 1)'(DEPTH));
        capture = pipe_q[PIPE_W-1];
        rd_pop  = read_i && ready_read_o;
        if (issue) begin
          mem_en_o  = 1'b1;
          mem_add_o = base_q + AW'(issued_q);
          issued_d  = issued_q + CNT_W'(1);
        end
        if (rd_pop) begin
          done_d = done_q + CNT_W'(1);
          if (done_q == count_q - CNT_W'(1)) begin
            state_d = S_IDLE;
          end
        end
      end

      S_WRITE: begin
        ready_write_o = !fifo_full && (recv_q < count_q);
        wr_push       = write_i && ready_write_o;
        mem_wr        = !fifo_empty;
        if (wr_push) begin
          recv_d = recv_q + CNT_W'(1);
        end
        if (mem_wr) begin
          mem_en_o  = 1'b1;
          mem_we_o  = 1'b1;
          mem_add_o = base_q + AW'(done_q);
          done_d    = done_q + CNT_W'(1);
          if (done_q == count_q - CNT_W'(1)) begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Offending strobes only raise the flag; they never reach the datapath
    error_d = error_q | (req_i & ~ready_req_o) | (write_i & ~ready_write_o) |
              (read_i & ~ready_read_o);

    // FIFO: a push lands behind the current head, a pop only retires a prior head
    push      = capture | wr_push;
    pop       = rd_pop | mem_wr;
    push_data = capture ? mem_data_i : data_i;
    if (push) begin
      fifo_d[wr_ptr_q] = push_data;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);

    pipe_d = PIPE_W'({pipe_q, issue});
  end

endmodule
